// File: rtl/ahb_arb_pkg.sv
// Shared types and HTRANS encodings for the two-master AHB-Lite arbiter.
package ahb_arb_pkg;

    localparam int ARB_AW = 32;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic [1:0]        trans;
        logic              write;
        logic [2:0]        size;
    } addr_phase_t;

    function automatic owner_t port_owner(input int idx);
        return (idx == 0) ? OWN_M0 : OWN_M1;
    endfunction

    // Beats that continue a burst and therefore keep the bus locked to their owner.
    function automatic logic holds_burst(input logic [1:0] trans);
        return (trans == TRANS_SEQ) || (trans == TRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb_arb_port.sv
// One master-side port: pending address-phase buffer, request selection and
// the per-master HREADY that hides arbitration stalls from the master.
module ahb_arb_port
    import ahb_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  addr_phase_t live,
    input  logic        slave_ready,
    input  logic        is_downer,
    input  logic        lock_own,
    input  logic        issue,
    output logic        req_vld,
    output addr_phase_t req,
    output logic        m_hready
);

    logic        pend_vld_reg;
    addr_phase_t pend_reg;
    logic        live_xfer;
    logic        live_vld;

    assign m_hready  = is_downer ? slave_ready : !pend_vld_reg;
    assign live_xfer = live.trans[1];
    // BUSY is only meaningful to the slave while this master holds the burst lock.
    assign live_vld  = m_hready && (live_xfer || ((live.trans == TRANS_BUSY) && lock_own));

    assign req_vld = pend_vld_reg || live_vld;
    assign req     = pend_vld_reg ? pend_reg : live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_reg <= 1'b0;
            pend_reg     <= '0;
        end else if (pend_vld_reg) begin
            if (issue) begin
                pend_vld_reg <= 1'b0;
            end
        end else if (live_vld && live_xfer && !issue) begin
            // The master saw HREADY high, so it believes this address was taken.
            pend_vld_reg <= 1'b1;
            pend_reg     <= live;
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter_2m.sv
// Two-master AHB-Lite arbiter in front of a single slave port: burst lock,
// round-robin on ties, and per-port address buffering for the losing master.
module ahb_bus_arbiter_2m
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA
);

    owner_t      downer_reg;
    owner_t      last_grant_reg;
    addr_phase_t last_phase_reg;

    addr_phase_t live    [2];
    addr_phase_t req     [2];
    logic [1:0]  req_vld;
    logic [1:0]  m_hready;
    logic [1:0]  lock;
    owner_t      win;
    owner_t      issued;
    addr_phase_t bus;

    assign live[0] = '{addr: M0_HADDR, trans: M0_HTRANS, write: M0_HWRITE, size: M0_HSIZE};
    assign live[1] = '{addr: M1_HADDR, trans: M1_HTRANS, write: M1_HWRITE, size: M1_HSIZE};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            ahb_arb_port u_port (
                .clk         (HCLK),
                .rst_n       (HRESETn),
                .live        (live[gi]),
                .slave_ready (HREADY),
                .is_downer   (downer_reg == port_owner(gi)),
                .lock_own    (last_grant_reg == port_owner(gi)),
                .issue       (issued == port_owner(gi)),
                .req_vld     (req_vld[gi]),
                .req         (req[gi]),
                .m_hready    (m_hready[gi])
            );

            assign lock[gi] = req_vld[gi] && (last_grant_reg == port_owner(gi))
                              && holds_burst(req[gi].trans);
        end
    endgenerate

    always_comb begin
        win = OWN_NONE;
        if (lock[0]) begin
            win = OWN_M0;
        end else if (lock[1]) begin
            win = OWN_M1;
        end else if (req_vld[0] && req_vld[1]) begin
            win = (last_grant_reg == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (req_vld[0]) begin
            win = OWN_M0;
        end else if (req_vld[1]) begin
            win = OWN_M1;
        end
    end

    // Nothing is presented to the slave while it stalls or while reset is held.
    assign issued = (HREADY && HRESETn) ? win : OWN_NONE;

    always_comb begin
        bus       = last_phase_reg;
        bus.trans = TRANS_IDLE;
        case (issued)
            OWN_M0:  bus = req[0];
            OWN_M1:  bus = req[1];
            default: ;
        endcase
    end

    assign HADDR  = bus.addr;
    assign HTRANS = bus.trans;
    assign HWRITE = bus.write;
    assign HSIZE  = bus.size;

    always_comb begin
        case (downer_reg)
            OWN_M0:  HWDATA = M0_HWDATA;
            OWN_M1:  HWDATA = M1_HWDATA;
            default: HWDATA = '0;
        endcase
    end

    assign M0_HREADY = m_hready[0];
    assign M1_HREADY = m_hready[1];
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            downer_reg     <= OWN_NONE;
            last_grant_reg <= OWN_M1;
            last_phase_reg <= '0;
        end else if (HREADY) begin
            downer_reg <= issued;
            if (issued != OWN_NONE) begin
                last_grant_reg <= issued;
                last_phase_reg <= bus;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter_2m.sv
// Directed bench for ahb_bus_arbiter_2m: expected slave address phases go into a
// scoreboard queue, a negedge monitor pops them as the DUT issues, and checks write data.
module tb_ahb_bus_arbiter_2m;
    import ahb_arb_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] M0_HADDR,  M1_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE,  M1_HSIZE;
    logic [63:0] M0_HWDATA, M1_HWDATA;
    logic        M0_HREADY, M1_HREADY;
    logic [63:0] M0_HRDATA, M1_HRDATA;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic [63:0] HRDATA;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic        chk_data;
        logic [63:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ahb_bus_arbiter_2m #(.AW(32), .DW(64)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .M0_HADDR  (M0_HADDR),
        .M0_HTRANS (M0_HTRANS),
        .M0_HWRITE (M0_HWRITE),
        .M0_HSIZE  (M0_HSIZE),
        .M0_HWDATA (M0_HWDATA),
        .M0_HREADY (M0_HREADY),
        .M0_HRDATA (M0_HRDATA),
        .M1_HADDR  (M1_HADDR),
        .M1_HTRANS (M1_HTRANS),
        .M1_HWRITE (M1_HWRITE),
        .M1_HSIZE  (M1_HSIZE),
        .M1_HWDATA (M1_HWDATA),
        .M1_HREADY (M1_HREADY),
        .M1_HRDATA (M1_HRDATA),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv_m0(input logic [1:0] t, input logic [31:0] a, input logic w);
        M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'b011;
    endtask

    task automatic drv_m1(input logic [1:0] t, input logic [31:0] a, input logic w);
        M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'b011;
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic cd, input logic [63:0] wd);
        exp_t e;
        e.addr = a; e.trans = t; e.write = w; e.size = 3'b011; e.chk_data = cd; e.wdata = wd;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: data-phase check for the previous beat, then address-phase pop.
    initial begin
        exp_t dphase;
        exp_t e;
        logic dphase_vld;
        dphase_vld = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dphase_vld = 1'b0;
            end else if (HREADY) begin
                if (dphase_vld && dphase.chk_data) begin
                    n_cmp++;
                    if (HWDATA !== dphase.wdata) begin
                        n_err++;
                        $display("FAIL hwdata @0x%0h: got 0x%0h, expected 0x%0h",
                                 dphase.addr, HWDATA, dphase.wdata);
                    end else begin
                        $display("data  addr=0x%0h hwdata=0x%0h", dphase.addr, HWDATA);
                    end
                end
                dphase_vld = 1'b0;
                if (HTRANS != TRANS_IDLE) begin
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_issue: got addr=0x%0h trans=%0d, expected none",
                                 HADDR, HTRANS);
                    end else begin
                        e = sb_q.pop_front();
                        if (HADDR !== e.addr || HTRANS !== e.trans ||
                            HWRITE !== e.write || HSIZE !== e.size) begin
                            n_err++;
                            $display("FAIL addr_phase: got addr=0x%0h trans=%0d wr=%0d size=%0d, expected addr=0x%0h trans=%0d wr=%0d size=%0d",
                                     HADDR, HTRANS, HWRITE, HSIZE, e.addr, e.trans, e.write, e.size);
                        end else begin
                            $display("issue addr=0x%0h trans=%0d wr=%0d", HADDR, HTRANS, HWRITE);
                        end
                        dphase     = e;
                        dphase_vld = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HRDATA  = '0;
        M0_HWDATA = '0;
        M1_HWDATA = '0;
        // A live request during reset must not reach the slave.
        drv_m0(TRANS_NONSEQ, 32'hDEAD_0000, 1'b1);
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        #2;
        chk("rst_htrans", HTRANS, TRANS_IDLE);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'b000);
        chk("rst_hwdata", HWDATA, 64'h0);
        chk("rst_m0_hready", M0_HREADY, 1'b1);
        chk("rst_m1_hready", M1_HREADY, 1'b1);
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        step();
        step();
        HRESETn = 1'b1;
        step();

        // Solo read from M0
        drv_m0(TRANS_NONSEQ, 32'h2000_0000, 1'b0);
        push(32'h2000_0000, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("solo_haddr_fwd", HADDR, 32'h2000_0000);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        HRDATA = 64'h1122_3344_5566_7788;
        #1 chk("solo_m0_hrdata", M0_HRDATA, 64'h1122_3344_5566_7788);
        chk("solo_m0_hready", M0_HREADY, 1'b1);
        step();

        // Simultaneous NONSEQ right after reset
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        step();
        drv_m0(TRANS_NONSEQ, 32'h0000_0100, 1'b1);
        drv_m1(TRANS_NONSEQ, 32'h0000_0200, 1'b1);
        push(32'h0000_0100, TRANS_NONSEQ, 1'b1, 1'b1, 64'hA0A0_0000_0000_0001);
        #1 chk("tie_m1_hready_capture", M1_HREADY, 1'b1);
        step();
        drv_m0(TRANS_NONSEQ, 32'h0000_0108, 1'b1);
        M0_HWDATA = 64'hA0A0_0000_0000_0001;
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        M1_HWDATA = 64'hB1B1_0000_0000_0002;
        push(32'h0000_0200, TRANS_NONSEQ, 1'b1, 1'b1, 64'hB1B1_0000_0000_0002);
        #1 chk("tie_m1_hready_pending", M1_HREADY, 1'b0);
        chk("tie_m0_hready_data", M0_HREADY, 1'b1);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        M0_HWDATA = 64'hA0A0_0000_0000_0003;
        push(32'h0000_0108, TRANS_NONSEQ, 1'b1, 1'b1, 64'hA0A0_0000_0000_0003);
        #1 chk("rr_m0_hready_pending", M0_HREADY, 1'b0);
        chk("rr_m1_hready_data", M1_HREADY, 1'b1);
        step();
        #1 chk("rr_m0_hready_data", M0_HREADY, 1'b1);
        step();

        // Burst lock: M0 INCR4, M1 requests from beat 2
        drv_m0(TRANS_NONSEQ, 32'h0000_0400, 1'b0);
        push(32'h0000_0400, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        step();
        drv_m0(TRANS_SEQ, 32'h0000_0408, 1'b0);
        drv_m1(TRANS_NONSEQ, 32'h0000_0500, 1'b0);
        push(32'h0000_0408, TRANS_SEQ, 1'b0, 1'b0, 64'h0);
        step();
        drv_m0(TRANS_SEQ, 32'h0000_0410, 1'b0);
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        push(32'h0000_0410, TRANS_SEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("burst_m1_hready_wait", M1_HREADY, 1'b0);
        step();
        drv_m0(TRANS_SEQ, 32'h0000_0418, 1'b0);
        push(32'h0000_0418, TRANS_SEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("burst_beat4_haddr", HADDR, 32'h0000_0418);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        push(32'h0000_0500, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("burst_m1_after_beat4", HADDR, 32'h0000_0500);
        step();
        #1 chk("burst_m1_hready_data", M1_HREADY, 1'b1);
        step();

        // Slave wait states with M1 pending
        drv_m0(TRANS_NONSEQ, 32'h0000_0600, 1'b1);
        drv_m1(TRANS_NONSEQ, 32'h0000_0700, 1'b1);
        push(32'h0000_0600, TRANS_NONSEQ, 1'b1, 1'b1, 64'hCCCC_0000_0000_0600);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        M0_HWDATA = 64'hCCCC_0000_0000_0600;
        M1_HWDATA = 64'hDDDD_0000_0000_0700;
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("wait_haddr_stable", HADDR, 32'h0000_0600);
            chk("wait_hwdata_m0", HWDATA, 64'hCCCC_0000_0000_0600);
            chk("wait_m1_hready", M1_HREADY, 1'b0);
            step();
        end
        HREADY = 1'b1;
        push(32'h0000_0700, TRANS_NONSEQ, 1'b1, 1'b1, 64'hDDDD_0000_0000_0700);
        #1 chk("wait_m1_issue", HADDR, 32'h0000_0700);
        step();
        #1 chk("wait_m1_hready_data", M1_HREADY, 1'b1);
        step();

        // Reset during a contended data phase
        drv_m0(TRANS_NONSEQ, 32'h0000_0800, 1'b1);
        drv_m1(TRANS_NONSEQ, 32'h0000_0900, 1'b1);
        push(32'h0000_0800, TRANS_NONSEQ, 1'b1, 1'b0, 64'h0);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        M0_HWDATA = 64'hEEEE_0000_0000_0800;
        M1_HWDATA = 64'hFFFF_0000_0000_0900;
        #1 HRESETn = 1'b0;
        #1 chk("midrst_htrans", HTRANS, TRANS_IDLE);
        chk("midrst_haddr", HADDR, 32'h0);
        chk("midrst_hwdata", HWDATA, 64'h0);
        chk("midrst_m0_hready", M0_HREADY, 1'b1);
        chk("midrst_m1_hready", M1_HREADY, 1'b1);
        step();
        HRESETn = 1'b1;
        step();
        drv_m0(TRANS_NONSEQ, 32'h0000_0A00, 1'b0);
        drv_m1(TRANS_NONSEQ, 32'h0000_0B00, 1'b0);
        push(32'h0000_0A00, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        push(32'h0000_0B00, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("postrst_m0_first", HADDR, 32'h0000_0A00);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        step();

        // M1 presents its next address while its pending one issues
        drv_m0(TRANS_NONSEQ, 32'h0000_0D00, 1'b0);
        drv_m1(TRANS_NONSEQ, 32'h0000_0C00, 1'b0);
        push(32'h0000_0D00, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        step();
        drv_m0(TRANS_IDLE, 32'h0, 1'b0);
        drv_m1(TRANS_NONSEQ, 32'h0000_0C08, 1'b0);
        push(32'h0000_0C00, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("pend_live_m1_hready", M1_HREADY, 1'b0);
        step();
        push(32'h0000_0C08, TRANS_NONSEQ, 1'b0, 1'b0, 64'h0);
        #1 chk("pend_live_second_haddr", HADDR, 32'h0000_0C08);
        chk("pend_live_m1_hready_data", M1_HREADY, 1'b1);
        step();
        drv_m1(TRANS_IDLE, 32'h0, 1'b0);
        step();
        step();
        step();

        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
